// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger controller.
// Holds the state encoding, the time-field widths, the timer widths and
// the default timing constants used by the top level and the bench.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam int unsigned RING_W = 8;   // ring_timer width
  localparam int unsigned SNZ_W  = 10;  // snooze_timer width
  localparam int unsigned CNT_W  = 3;   // snooze_cnt width

  localparam int unsigned RING_TIMEOUT_S_DEF = 60;
  localparam int unsigned SNOOZE_S_DEF       = 300;
  localparam int unsigned MAX_SNOOZE_DEF     = 3;

  // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_time_match.sv
// Trigger qualifier for the alarm FSM: purely combinational.
// Ports:
//   armed_i, tick_i            - alarm enable level and 1 Hz tick pulse
//   cur_hour_i/min_i/sec_i     - wall-clock time
//   alarm_hour_i/min_i         - programmed alarm time
//   trigger_c                  - armed && tick && hh:mm match && sec==0
module alarm_time_match
  import alarm_pkg::*;
(
  input  logic              armed_i,
  input  logic              tick_i,
  input  logic [HOUR_W-1:0] cur_hour_i,
  input  logic [MIN_W-1:0]  cur_min_i,
  input  logic [SEC_W-1:0]  cur_sec_i,
  input  logic [HOUR_W-1:0] alarm_hour_i,
  input  logic [MIN_W-1:0]  alarm_min_i,
  output logic              trigger_c
);

  // Qualifying on sec==0 limits the trigger to one tick per matching minute.
  assign trigger_c = armed_i && tick_i
                  && (cur_hour_i == alarm_hour_i)
                  && (cur_min_i  == alarm_min_i)
                  && (cur_sec_i  == SEC_W'(0));

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Alarm trigger controller: compares time with the alarm setting and runs
// the IDLE / RINGING / SNOOZE state machine that drives the tone player.
// Ports:
//   clk, reset (async, active-high), tick_1hz (1-cycle pulse per second)
//   cur_hour/min/sec, alarm_hour/min, alarm_armed (level)
//   stop_btn, snooze_btn (1-cycle debounced pulses)
//   playerEnable (high while ringing), stop (high = amplifier shut down)
//   alarm_event (1-cycle pulse on IDLE->RINGING), state_out, snooze_cnt
// All outputs are registered and update with the state register.
module alarm_trigger_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int unsigned SNOOZE_S       = SNOOZE_S_DEF,
  parameter int unsigned MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_armed,
  input  logic              stop_btn,
  input  logic              snooze_btn,
  output logic              playerEnable,
  output logic              stop,
  output logic              alarm_event,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  snooze_cnt
);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_S);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_SNOOZE);

  state_t             state_q, state_d;
  logic [RING_W-1:0]  ring_q, ring_d;
  logic [SNZ_W-1:0]   snz_q, snz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               event_q, event_d;
  logic               pe_q, pe_d;
  logic               stop_q, stop_d;
  logic               trigger_c;

  alarm_time_match u_match (
    .armed_i      (alarm_armed),
    .tick_i       (tick_1hz),
    .cur_hour_i   (cur_hour),
    .cur_min_i    (cur_min),
    .cur_sec_i    (cur_sec),
    .alarm_hour_i (alarm_hour),
    .alarm_min_i  (alarm_min),
    .trigger_c    (trigger_c)
  );

  // State, timers and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      cnt_q   <= '0;
      event_q <= 1'b0;
      pe_q    <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      pe_q    <= pe_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state, timer and output logic.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;

    if (!alarm_armed) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trigger_c) begin
            state_d = RINGING;
            ring_d  = '0;
            event_d = 1'b1;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state_d = IDLE;
          end else if (snooze_btn && (cnt_q < CNT_MAX)) begin
            state_d = SNOOZE;
            cnt_d   = cnt_q + CNT_W'(1);
            snz_d   = SNZ_LOAD;
          end else if (tick_1hz) begin
            // An ignored snooze press falls through to normal tick counting.
            if (ring_q == RING_LAST) state_d = IDLE;
            else                     ring_d  = ring_q + RING_W'(1);
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_d = IDLE;
          end else if (tick_1hz) begin
            if (snz_q == SNZ_W'(1)) begin
              state_d = RINGING;
              ring_d  = '0;
            end else begin
              snz_d = snz_q - SNZ_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Every entry into IDLE closes the alarm event.
    if (state_d == IDLE) begin
      cnt_d  = '0;
      ring_d = '0;
      snz_d  = '0;
    end

    pe_d   = (state_d == RINGING);
    stop_d = (state_d != RINGING);
  end

  assign playerEnable = pe_q;
  assign stop         = stop_q;
  assign alarm_event  = event_q;
  assign state_out    = state_q;
  assign snooze_cnt   = cnt_q;

endmodule

// File: doc/alarm_trigger_ctrl.md
Name: alarm_trigger_ctrl

Overview:
Upstream controller for the alarm tone player. It compares wall-clock time against the programmed alarm time and runs the ring/snooze/dismiss state machine. It drives the player's enable and amplifier-shutdown controls (playerEnable, stop). It sits between the timekeeping counter and the player, and is advanced by the 1 Hz tick.

Parameters:
RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-dismiss (1..255)
SNOOZE_S, 300, seconds spent in snooze before re-ringing (1..1023)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7); further snooze presses are ignored

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk
cur_hour  in  5  current hour, 0..23
cur_min  in  6  current minute, 0..59
cur_sec  in  6  current second, 0..59
alarm_hour  in  5  programmed alarm hour
alarm_min  in  6  programmed alarm minute
alarm_armed  in  1  level; alarm enabled by user switch
stop_btn  in  1  debounced one-cycle pulse; dismiss
snooze_btn  in  1  debounced one-cycle pulse; snooze
playerEnable  out  1  high while ringing; low holds the player in reset
stop  out  1  amplifier shutdown request to the player; high = silent
alarm_event  out  1  one-cycle pulse on each IDLE->RINGING trigger
state_out  out  2  current state, for LEDs and debug
snooze_cnt  out  3  snoozes used in the current alarm event

Behaviour:
- Reset (async, any time): state=IDLE, playerEnable=0, stop=1, alarm_event=0, snooze_cnt=0; ring and snooze timers cleared.
- All outputs are registered and change on the same clk edge as the state register.
- States, with encoding on state_out: IDLE=0, RINGING=1, SNOOZE=2. Encoding 3 is unused and recovers to IDLE on the next edge.
- IDLE:
  - Trigger when alarm_armed && tick_1hz && cur_hour==alarm_hour && cur_min==alarm_min && cur_sec==0.
  - On trigger: go to RINGING, ring_timer=0, pulse alarm_event for exactly 1 cycle.
  - Hence trigger fires at most once per day per match; no retrigger within the same minute after dismissal.
- RINGING (playerEnable=1, stop=0):
  - Each tick increments ring_timer (8 bits).
  - On the tick where ring_timer==RING_TIMEOUT_S-1, go to IDLE, i.e. exactly RING_TIMEOUT_S ticks after entry.
  - stop_btn -> IDLE.
  - snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE: snooze_cnt+1, snooze_timer=SNOOZE_S.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; ringing continues and ring_timer is not cleared.
- SNOOZE (playerEnable=0, stop=1):
  - Each tick decrements snooze_timer (10 bits).
  - On the tick where snooze_timer==1, go to RINGING with ring_timer=0. alarm_event does not pulse on this transition.
  - stop_btn -> IDLE.
  - snooze_btn is ignored.
- Any state with alarm_armed==0 -> IDLE on the next edge. This has highest priority after reset.
- Entering IDLE from any state clears snooze_cnt to 0.
- Priority within one cycle: reset > !alarm_armed > stop_btn > snooze_btn > timer expiry > tick counting.
  - stop_btn and snooze_btn together: dismiss.
  - stop_btn on the timeout tick: dismiss. Either way the result is IDLE.
- Timers only advance on tick_1hz. Without ticks, state is held indefinitely.
- Timer arithmetic is unsigned. Counters never wrap, because each expires before overflow given the parameter ranges.

Decomposition:
- Shared package (alarm_pkg):
  - state encoding constants IDLE/RINGING/SNOOZE;
  - widths HOUR_W=5, MIN_W=6, SEC_W=6;
  - default timing constants for reuse by the top level and the bench.
- One natural sub-module: alarm_time_match. It is the registered-free equality comparator producing the trigger qualifier (armed, tick, hh:mm match, sec==0). The FSM, timers and outputs stay in alarm_trigger_ctrl.

Test Plan:
- Trigger:
  - Stimulus: alarm 07:30, armed, time steps 07:29:59 -> 07:30:00 with a tick.
  - Required: next edge state_out=1, playerEnable=1, stop=0, alarm_event high for 1 cycle.
  - Same stimulus with alarm_armed=0: no change.
- Timeout (RING_TIMEOUT_S=5):
  - Stimulus: trigger, then 4 ticks; then a 5th tick.
  - Required: still RINGING after 4 ticks; after the 5th, state_out=0, playerEnable=0, stop=1.
- Snooze cycle (SNOOZE_S=3, MAX_SNOOZE=2):
  - Stimulus: snooze while ringing; then 3 ticks; then two more snooze presses during the following rings.
  - Required: SNOOZE, playerEnable=0, snooze_cnt=1; back to RINGING after 3 ticks with alarm_event low.
  - The 2nd snooze is accepted; the 3rd is ignored and snooze_cnt stays 2.
- Simultaneous events: stop_btn and snooze_btn in the same cycle while RINGING -> IDLE, snooze_cnt=0.
- Disarm mid-snooze: alarm_armed drops while in SNOOZE -> IDLE next edge, stop=1, no re-ring after SNOOZE_S ticks.
- Async reset mid-RINGING:
  - Stimulus: reset asserted between clock edges.
  - Required: playerEnable=0, stop=1, state_out=0 immediately, without waiting for a clk edge.
  - After release, a re-match at the next hh:mm:00 triggers normally.
